// File: rtl/cache_line_controller_pkg.sv
// Shared constants, state encoding and address-field helpers for the
// direct-mapped read-only cache line controller.
package cache_line_controller_pkg;

  localparam int c_CPU_ADDR_SIZE    = 16;
  localparam int c_INDEX_SIZE       = 4;
  localparam int c_ADDR_OFFSET_SIZE = 4;
  localparam int c_TAG_SIZE         = c_CPU_ADDR_SIZE - c_INDEX_SIZE - c_ADDR_OFFSET_SIZE;
  localparam int c_LINES            = 1 << c_INDEX_SIZE;
  localparam int c_LINE_ADDR_SIZE   = c_CPU_ADDR_SIZE - c_ADDR_OFFSET_SIZE;
  localparam int c_STAT_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_FILL    = 2'd2,
    ST_RESPOND = 2'd3
  } cache_state_e;

  function automatic logic [c_INDEX_SIZE-1:0] addr_index(input logic [c_CPU_ADDR_SIZE-1:0] a);
    return a[c_ADDR_OFFSET_SIZE +: c_INDEX_SIZE];
  endfunction

  function automatic logic [c_TAG_SIZE-1:0] addr_tag(input logic [c_CPU_ADDR_SIZE-1:0] a);
    return a[c_CPU_ADDR_SIZE-1 -: c_TAG_SIZE];
  endfunction

  function automatic logic [c_STAT_W-1:0] sat_inc(input logic [c_STAT_W-1:0] v);
    return (v == {c_STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag and valid arrays for the cache: combinational hit lookup, single-entry
// write and single-cycle clear of all valid bits.
module cache_tag_store
  import cache_line_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [c_INDEX_SIZE-1:0] lookup_index,
  input  logic [c_TAG_SIZE-1:0]   lookup_tag,
  output logic                    lookup_hit,
  input  logic                    wr_en,
  input  logic [c_INDEX_SIZE-1:0] wr_index,
  input  logic [c_TAG_SIZE-1:0]   wr_tag,
  input  logic                    clr_all
);

  logic [c_LINES-1:0]    valid_q, valid_d;
  logic [c_TAG_SIZE-1:0] tag_q [c_LINES];
  logic [c_TAG_SIZE-1:0] tag_d [c_LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tags are qualified by their valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign lookup_hit = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);

endmodule

// File: rtl/cache_line_controller.sv
// Sequencing controller for a direct-mapped read-only cache: lookup, line fill
// over a req/ack RAM handshake, data-memory control. Optional hit/miss
// counters are enabled with CACHE_LINE_CONTROLLER_STATS_EN.
module cache_line_controller
  import cache_line_controller_pkg::*;
(
  input  logic                          IN_CLK,
  input  logic                          IN_RST_N,
  input  logic                          IN_CPU_REQ,
  input  logic [c_CPU_ADDR_SIZE-1:0]    IN_CPU_ADDR,
  input  logic                          IN_FLUSH,
  output logic                          OUT_CPU_BUSY,
  output logic                          OUT_CPU_READY,
  output logic                          OUT_RAM_REQ,
  output logic [c_LINE_ADDR_SIZE-1:0]   OUT_RAM_ADDR,
  input  logic                          IN_RAM_ACK,
  output logic [c_INDEX_SIZE-1:0]       OUT_DMEM_INDEX,
  output logic                          OUT_DMEM_WE,
  output logic [c_ADDR_OFFSET_SIZE-1:0] OUT_DMEM_OFFSET
`ifdef CACHE_LINE_CONTROLLER_STATS_EN
  ,
  output logic [c_STAT_W-1:0]           OUT_HIT_CNT,
  output logic [c_STAT_W-1:0]           OUT_MISS_CNT
`endif
);

  cache_state_e                state_q, state_d;
  logic [c_CPU_ADDR_SIZE-1:0]  addr_q, addr_d;
  logic                        flush_pend_q, flush_pend_d;
  logic                        ram_req_q, ram_req_d;
  logic [c_LINE_ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic                        ready_q, ready_d;

  logic hit;
  logic fill_done;
  logic clr_all;

  assign fill_done = (state_q == ST_FILL) && IN_RAM_ACK;
  assign clr_all   = (state_q == ST_IDLE) && flush_pend_q;

  cache_tag_store u_tag_store (
    .clk          (IN_CLK),
    .rst_n        (IN_RST_N),
    .lookup_index (addr_index(addr_q)),
    .lookup_tag   (addr_tag(addr_q)),
    .lookup_hit   (hit),
    .wr_en        (fill_done),
    .wr_index     (addr_index(addr_q)),
    .wr_tag       (addr_tag(addr_q)),
    .clr_all      (clr_all)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q;
    ram_req_d    = ram_req_q;
    ram_addr_d   = ram_addr_q;
    case (state_q)
      ST_IDLE: begin
        // A pending flush owns this cycle; a flush arriving now also beats a request.
        if (flush_pend_q) begin
          flush_pend_d = 1'b0;
        end else if (IN_CPU_REQ && !IN_FLUSH) begin
          addr_d  = IN_CPU_ADDR;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          state_d = ST_RESPOND;
        end else begin
          ram_req_d  = 1'b1;
          ram_addr_d = addr_q[c_CPU_ADDR_SIZE-1:c_ADDR_OFFSET_SIZE];
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (IN_RAM_ACK) begin
          ram_req_d = 1'b0;
          state_d   = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (IN_FLUSH) flush_pend_d = 1'b1;
    ready_d = (state_d == ST_RESPOND);
  end

  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_addr_q   <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      ram_req_q    <= ram_req_d;
      ram_addr_q   <= ram_addr_d;
      ready_q      <= ready_d;
    end
  end

  assign OUT_CPU_BUSY    = (state_q != ST_IDLE) || flush_pend_q;
  assign OUT_CPU_READY   = ready_q;
  assign OUT_RAM_REQ     = ram_req_q;
  assign OUT_RAM_ADDR    = ram_addr_q;
  assign OUT_DMEM_WE     = fill_done;
  // The latched address only changes on acceptance, so it holds through IDLE.
  assign OUT_DMEM_INDEX  = addr_index(addr_q);
  assign OUT_DMEM_OFFSET = addr_q[c_ADDR_OFFSET_SIZE-1:0];

`ifdef CACHE_LINE_CONTROLLER_STATS_EN
  logic [c_STAT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [c_STAT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_LOOKUP) begin
      if (hit) hit_cnt_d  = sat_inc(hit_cnt_q);
      else     miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign OUT_HIT_CNT  = hit_cnt_q;
  assign OUT_MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_line_controller.sv
// Bench for cache_line_controller: timestamp-based transaction model checked
// every cycle, plus directed reads with hand-computed latencies and fields.
module tb_cache_line_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [15:0] addr = 16'h0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic        busy, ready, ram_req, dmem_we;
  logic [11:0] ram_addr;
  logic [3:0]  dmem_index, dmem_offset;
`ifdef CACHE_LINE_CONTROLLER_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  cache_line_controller dut (
    .IN_CLK          (clk),
    .IN_RST_N        (rst_n),
    .IN_CPU_REQ      (req),
    .IN_CPU_ADDR     (addr),
    .IN_FLUSH        (flush),
    .OUT_CPU_BUSY    (busy),
    .OUT_CPU_READY   (ready),
    .OUT_RAM_REQ     (ram_req),
    .OUT_RAM_ADDR    (ram_addr),
    .IN_RAM_ACK      (ack),
    .OUT_DMEM_INDEX  (dmem_index),
    .OUT_DMEM_WE     (dmem_we),
    .OUT_DMEM_OFFSET (dmem_offset)
`ifdef CACHE_LINE_CONTROLLER_STATS_EN
    ,
    .OUT_HIT_CNT     (hit_cnt),
    .OUT_MISS_CNT    (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired, got no event, expected one (cycle %0d)", nm, cyc);
  endtask

  // Model: a transaction accepted at cycle A is a hit or miss against the
  // model's own valid/tag arrays. Hit -> READY at A+2. Miss -> RAM_REQ from
  // A+2 through the ack cycle K, READY at K+1. Busy spans A+1..READY.
  bit          m_active, m_hit, m_acked, m_pend;
  int          m_acc, m_ack, m_hits, m_misses;
  logic [15:0] m_addr;
  bit          m_valid [16];
  logic [7:0]  m_tag [16];

  always @(negedge clk) begin : compare
    bit ready_e, rreq_e, we_e, busy_e, act0, pend0;
    int ix;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 0);
      chk("rst_ram_req", ram_req, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_dmem_we", dmem_we, 0);
      chk("rst_dmem_index", dmem_index, 0);
      chk("rst_dmem_offset", dmem_offset, 0);
      m_active = 0; m_pend = 0; m_addr = 16'h0; m_hits = 0; m_misses = 0;
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
    end else begin
      act0    = m_active;
      pend0   = m_pend;
      ix      = int'(m_addr[7:4]);
      ready_e = act0 && (m_hit ? (cyc == m_acc + 2) : (m_acked && cyc == m_ack + 1));
      rreq_e  = act0 && !m_hit && (cyc >= m_acc + 2) && !m_acked;
      we_e    = rreq_e && ack;
      busy_e  = act0 || pend0;
      chk("busy", busy, busy_e);
      chk("ready", ready, ready_e);
      chk("ram_req", ram_req, rreq_e);
      chk("dmem_we", dmem_we, we_e);
      chk("dmem_index", dmem_index, m_addr[7:4]);
      chk("dmem_offset", dmem_offset, m_addr[3:0]);
      if (rreq_e) chk("ram_addr", ram_addr, m_addr[15:4]);
`ifdef CACHE_LINE_CONTROLLER_STATS_EN
      chk("hit_cnt", hit_cnt, m_hits);
      chk("miss_cnt", miss_cnt, m_misses);
`endif
      if (act0 && cyc == m_acc + 1) begin
        if (m_hit) m_hits++;
        else       m_misses++;
      end
      if (we_e) begin
        m_acked = 1; m_ack = cyc; m_valid[ix] = 1; m_tag[ix] = m_addr[15:8];
      end
      if (ready_e) m_active = 0;
      if (!act0) begin
        if (pend0) begin
          for (int i = 0; i < 16; i++) m_valid[i] = 0;
          m_pend = 0;
        end else if (req && !flush) begin
          m_active = 1; m_acc = cyc; m_addr = addr; m_acked = 0;
          m_hit = m_valid[addr[7:4]] && (m_tag[addr[7:4]] == addr[15:8]);
        end
      end
      if (flush) m_pend = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read; ack arrives in the dly-th cycle of RAM_REQ; optional flush
  // pulse on wait-loop iteration flush_at. Returns in the READY cycle.
  task automatic cpu_read(input logic [15:0] a, input int dly, input int flush_at,
                          output int lat, output bit missed, output logic [11:0] ra,
                          output int waited);
    int n, cnt, t0;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    waited = n;
    lat = -1; missed = 0; ra = 12'h0;
    if (busy) begin timeout("accept"); return; end
    req = 1'b1; addr = a; t0 = cyc;
    tick();
    req = 1'b0;
    n = 0; cnt = 0;
    while (n < 100) begin
      if (ready) begin lat = cyc - t0; break; end
      if (ram_req) begin
        missed = 1; ra = ram_addr; cnt++;
        if (cnt == dly) ack = 1'b1;
      end
      if (n == flush_at) flush = 1'b1;
      tick();
      ack = 1'b0; flush = 1'b0; n++;
    end
    if (lat < 0) timeout("ready");
  endtask

  initial begin
    int lat, w;
    bit miss;
    logic [11:0] ra;

    repeat (3) tick();
    chk("reset_busy_lit", busy, 0);
    chk("reset_ram_req_lit", ram_req, 0);
    rst_n = 1'b1;
    tick();

    cpu_read(16'h1234, 3, -1, lat, miss, ra, w);
    chk("cold_lat", lat, 5);
    chk("cold_missed", miss, 1);
    chk("cold_ram_addr", ra, 12'h123);
    chk("cold_index", dmem_index, 4'h3);
    chk("cold_offset", dmem_offset, 4'h4);

    cpu_read(16'h1238, 0, -1, lat, miss, ra, w);
    chk("hit_lat", lat, 2);
    chk("hit_missed", miss, 0);
    chk("hit_offset", dmem_offset, 4'h8);

    cpu_read(16'h5234, 1, -1, lat, miss, ra, w);
    chk("conflict_lat", lat, 3);
    chk("conflict_missed", miss, 1);
    chk("conflict_ram_addr", ra, 12'h523);
    cpu_read(16'h1234, 2, -1, lat, miss, ra, w);
    chk("conflict_back_lat", lat, 4);
    chk("conflict_back_missed", miss, 1);

    cpu_read(16'h1234, 0, -1, lat, miss, ra, w);
    chk("rehit_missed", miss, 0);
    cpu_read(16'h9234, 4, 2, lat, miss, ra, w);
    chk("flushfill_lat", lat, 6);
    chk("flushfill_missed", miss, 1);
    tick();
    chk("flush_busy_after", busy, 1);
    cpu_read(16'h9234, 1, -1, lat, miss, ra, w);
    chk("after_flush_missed", miss, 1);

    tick();
    req = 1'b1; flush = 1'b1; addr = 16'h9238;
    tick();
    req = 1'b0; flush = 1'b0;
    chk("coinc_busy", busy, 1);
    tick();
    chk("coinc_idle", busy, 0);
    cpu_read(16'h9238, 1, -1, lat, miss, ra, w);
    chk("coinc_missed", miss, 1);
    chk("coinc_lat", lat, 3);

    tick();
    req = 1'b1; addr = 16'h4321;
    tick();
    req = 1'b0;
    tick();
    chk("midfill_req_up", ram_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("midfill_req_drop", ram_req, 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("midfill_busy_rel", busy, 0);
    tick();
    cpu_read(16'h4321, 2, -1, lat, miss, ra, w);
    chk("midfill_again_missed", miss, 1);
    chk("midfill_again_lat", lat, 4);

    cpu_read(16'h4325, 0, -1, lat, miss, ra, w);
    chk("b2b_first_lat", lat, 2);
    chk("b2b_first_wait", w, 1);
    cpu_read(16'h432C, 0, -1, lat, miss, ra, w);
    chk("b2b_second_wait", w, 1);
    chk("b2b_second_missed", miss, 0);
    chk("b2b_offset", dmem_offset, 4'hC);

`ifdef CACHE_LINE_CONTROLLER_STATS_EN
    tick();
    chk("stats_hits", hit_cnt, 16'd2);
    chk("stats_misses", miss_cnt, 16'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    chk("stats_hits_flush", hit_cnt, 16'd2);
    chk("stats_misses_flush", miss_cnt, 16'd1);
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
